wbuf_drain: RTL and testbench

Read-side engine for the write-data FIFO. It pops words from the FIFO's read port one at a time and presents them to the DRAM-cache write path as beats on a valid/ready interface, grouped into fixed-length bursts with a last-beat marker. It sits between the write-buffer FIFO output (almost-empty / read-enable / read-data) and the cache write controller, and is the consumer that `rden` on the FIFO was built for.

---
 rtl/wbuf_drain_pkg.sv | 22 ++
 rtl/wbuf_drain.sv | 175 +++++++++++++++++
 tb/tb_wbuf_drain.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbuf_drain_pkg.sv
// -----------------------------------------------------------------------------
// wbuf_drain_pkg
//   Shared definitions for the write-buffer drain engine:
//     - state_e        : drain FSM state encoding (2 bits)
//     - AXI_DATA_WIDTH : default beat / FIFO word width
//     - WBUF_BURST_LEN : default beats per burst
//     - FIFO_SIZE      : depth of the write-data FIFO this engine drains
// -----------------------------------------------------------------------------
package wbuf_drain_pkg;

  localparam int AXI_DATA_WIDTH = 32;
  localparam int WBUF_BURST_LEN = 4;
  localparam int FIFO_SIZE      = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_CAP  = 2'd2,
    S_SEND = 2'd3
  } state_e;

endpackage

// File: rtl/wbuf_drain.sv
// -----------------------------------------------------------------------------
// wbuf_drain
//   Read-side engine of the write-data FIFO. Pops one word at a time and
//   presents it as a valid/ready beat to the DRAM-cache write path, grouping
//   beats into BURST_LEN-long bursts with a last-beat marker. Only one word is
//   ever held, so a pop is never issued while a beat waits on wready_i.
//
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     aempty_i          FIFO almost-empty (1 = nothing may be popped)
//     rden_o            FIFO read enable, one-cycle pulse per word
//     rdata_i           FIFO read data, valid the cycle after rden_o
//     wvalid_o/wready_i beat handshake toward the cache write path
//     wdata_o, wlast_o  beat data and last-beat-of-burst marker
//     busy_o            burst partially sent or a word in flight
//     beats_o, bursts_o handshake / completed-burst counters
//                       (only when WBUF_DRAIN_STATS_EN is defined)
//
//   Build option: WBUF_DRAIN_STATS_EN adds the two 32-bit statistics ports.
//   All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module wbuf_drain
  import wbuf_drain_pkg::*;
#(
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int BURST_LEN  = WBUF_BURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aempty_i,
  output logic                  rden_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  wvalid_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wlast_o,
  input  logic                  wready_i,
  output logic                  busy_o
`ifdef WBUF_DRAIN_STATS_EN
  ,
  output logic [31:0]           beats_o,
  output logic [31:0]           bursts_o
`endif
);

  // A 1-bit counter is kept for BURST_LEN=1; it never leaves 0 because the
  // last-beat compare against LAST_BEAT (=0) is then always true.
  localparam int              CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    last_q, last_d;
  logic                    rden_q, rden_d;
  logic                    wvalid_q, wvalid_d;
  logic                    busy_q, busy_d;
  logic                    hs_s;

  assign hs_s = wvalid_q & wready_i;

  // Next-state, beat counter and beat register update.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    data_d     = data_q;
    last_d     = last_q;

    case (state_q)
      S_IDLE: begin
        // beat_cnt is left alone so a burst can stall here mid-way
        if (!aempty_i) begin
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        data_d  = rdata_i;
        last_d  = (beat_cnt_q == LAST_BEAT);
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs_s) begin
          if (last_q) begin
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
          // aempty_i is only looked at here and in S_IDLE
          if (aempty_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_POP;
          end
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flops are loaded from the next state so they line up with it.
    rden_d   = (state_d == S_POP);
    wvalid_d = (state_d == S_SEND);
    busy_d   = (state_d != S_IDLE) || (beat_cnt_d != '0);
  end

  // State, beat and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      rden_q     <= 1'b0;
      wvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
      rden_q     <= rden_d;
      wvalid_q   <= wvalid_d;
      busy_q     <= busy_d;
    end
  end

  assign rden_o   = rden_q;
  assign wvalid_o = wvalid_q;
  assign wdata_o  = data_q;
  assign wlast_o  = last_q;
  assign busy_o   = busy_q;

`ifdef WBUF_DRAIN_STATS_EN
  logic [31:0] beats_q, beats_d;
  logic [31:0] bursts_q, bursts_d;

  // Handshake and completed-burst counters, wrapping modulo 2^32.
  always_comb begin
    beats_d  = beats_q;
    bursts_d = bursts_q;
    if (hs_s) begin
      beats_d = beats_q + 32'd1;
      if (last_q) begin
        bursts_d = bursts_q + 32'd1;
      end else begin
        bursts_d = bursts_q;
      end
    end else begin
      beats_d = beats_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beats_q  <= 32'd0;
      bursts_q <= 32'd0;
    end else begin
      beats_q  <= beats_d;
      bursts_q <= bursts_d;
    end
  end

  assign beats_o  = beats_q;
  assign bursts_o = bursts_q;
`endif

endmodule

// File: tb/tb_wbuf_drain.sv
// -----------------------------------------------------------------------------
// tb_wbuf_drain
//   Scoreboard bench for wbuf_drain. A behavioural FIFO feeds each DUT; every
//   pushed word also pushes its expected beat (data, last) into a queue, and a
//   negedge monitor pops and compares on each handshake. dut0 uses the default
//   burst length of 4, dut1 uses BURST_LEN=1.
// -----------------------------------------------------------------------------
module tb_wbuf_drain;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          aempty_i, rden_o, wvalid_o, wlast_o, wready_i, busy_o;
  logic [DW-1:0] rdata_i, wdata_o;
  logic          aempty1_i, rden1_o, wvalid1_o, wlast1_o, wready1_i, busy1_o;
  logic [DW-1:0] rdata1_i, wdata1_o;
`ifdef WBUF_DRAIN_STATS_EN
  logic [31:0]   beats_o, bursts_o, beats1_o, bursts1_o;
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int fifo_cnt  = 0;
  int fifo1_cnt = 0;
  int burst_idx = 0;

  beat_t         exp_q[$];
  beat_t         exp1_q[$];
  logic [DW-1:0] fifo_q[$], pend_q[$], fifo1_q[$], pend1_q[$];
  int            rden_log[$];

  wbuf_drain #(.DATA_WIDTH(DW), .BURST_LEN(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .aempty_i(aempty_i), .rden_o(rden_o),
    .rdata_i(rdata_i), .wvalid_o(wvalid_o), .wdata_o(wdata_o),
    .wlast_o(wlast_o), .wready_i(wready_i), .busy_o(busy_o)
`ifdef WBUF_DRAIN_STATS_EN
    , .beats_o(beats_o), .bursts_o(bursts_o)
`endif
  );

  wbuf_drain #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .aempty_i(aempty1_i), .rden_o(rden1_o),
    .rdata_i(rdata1_i), .wvalid_o(wvalid1_o), .wdata_o(wdata1_o),
    .wlast_o(wlast1_o), .wready_i(wready1_i), .busy_o(busy1_o)
`ifdef WBUF_DRAIN_STATS_EN
    , .beats_o(beats1_o), .bursts_o(bursts1_o)
`endif
  );

  assign aempty_i  = (fifo_cnt == 0);
  assign aempty1_i = (fifo1_cnt == 0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // FIFO models: pop on rden, then append pending pushes; flushed by reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      fifo_q.delete();
      fifo1_q.delete();
      fifo_cnt  <= 0;
      fifo1_cnt <= 0;
      rdata_i   <= '0;
      rdata1_i  <= '0;
    end else begin
      if (rden_o && fifo_q.size() > 0) rdata_i <= fifo_q.pop_front();
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
      fifo_cnt <= fifo_q.size();
      if (rden1_o && fifo1_q.size() > 0) rdata1_i <= fifo1_q.pop_front();
      while (pend1_q.size() > 0) fifo1_q.push_back(pend1_q.pop_front());
      fifo1_cnt <= fifo1_q.size();
    end
  end

  // dut0 monitor: protocol checks plus scoreboard compare on each handshake.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (rden_o) begin
        chk("rden_while_aempty", aempty_i, 1'b0);
        rden_log.push_back(cyc);
      end
      if (wvalid_o) chk("rden_during_beat", rden_o, 1'b0);
      if (prev_stall) begin
        chk("hold_valid", wvalid_o, 1'b1);
        chk("hold_data", wdata_o, prev_data);
        chk("hold_last", wlast_o, prev_last);
      end
      if (wvalid_o && wready_i) begin
        if (exp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_beat: got data %h with no beat expected", wdata_o);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", wdata_o, e.data);
          chk("beat_last", wlast_o, e.last);
        end
      end
      prev_stall = wvalid_o && !wready_i;
      prev_data  = wdata_o;
      prev_last  = wlast_o;
    end
  end

  // dut1 monitor (BURST_LEN=1).
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (rden1_o) chk("rden1_while_aempty", aempty1_i, 1'b0);
      if (wvalid1_o && wready1_i) begin
        if (exp1_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_beat1: got data %h with no beat expected", wdata1_o);
        end else begin
          e = exp1_q.pop_front();
          chk("beat1_data", wdata1_o, e.data);
          chk("beat1_last", wlast1_o, e.last);
        end
      end
    end
  end

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      pend_q.push_back(base + DW'(i));
      exp_q.push_back('{data: base + DW'(i), last: (burst_idx == 3)});
      burst_idx = (burst_idx + 1) % 4;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic wait_valid(input int bound);
    int k = 0;
    while (!wvalid_o && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wvalid_timeout", wvalid_o, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int k;
    rst_n     = 1'b0;
    wready_i  = 1'b0;
    wready1_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rden", rden_o, 1'b0);
    chk("rst_wvalid", wvalid_o, 1'b0);
    chk("rst_wlast", wlast_o, 1'b0);
    chk("rst_wdata", wdata_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full 4-beat burst with wready held high: pops every 3 cycles.
    wready_i = 1'b1;
    rden_log.delete();
    push_words(4, 32'hD000_0000);
    t0 = cyc;
    wait_drain(40);
    @(negedge clk);
    chk("busy_after_burst", busy_o, 1'b0);
    chk("rden_count", rden_log.size(), 4);
    for (int i = 0; i < 4 && i < rden_log.size(); i++)
      chk("rden_cycle", rden_log[i], t0 + 1 + 3 * i);
`ifdef WBUF_DRAIN_STATS_EN
    chk("stats_beats", beats_o, 32'd4);
    chk("stats_bursts", bursts_o, 32'd1);
`endif

    // Second beat stalled 5 cycles by wready_i low.
    @(posedge clk); #1;
    wready_i = 1'b0;
    push_words(4, 32'h1111_0000);
    wait_valid(20);
    wready_i = 1'b1;
    @(posedge clk); #1;
    wready_i = 1'b0;
    wait_valid(20);
    chk("stall_data_d1", wdata_o, 32'h1111_0001);
    repeat (5) @(posedge clk);
    #1;
    wready_i = 1'b1;
    wait_drain(40);
    @(negedge clk);
    chk("busy_after_stall", busy_o, 1'b0);

    // Only 2 words: burst parks in S_IDLE mid-way, then resumes.
    @(posedge clk); #1;
    push_words(2, 32'h2222_0000);
    wait_drain(40);
    @(negedge clk);
    chk("park_busy", busy_o, 1'b1);
    chk("park_wvalid", wvalid_o, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("park_busy_held", busy_o, 1'b1);
    push_words(2, 32'h2222_0002);
    wait_drain(40);
    @(negedge clk);
    chk("busy_after_resume", busy_o, 1'b0);

    // BURST_LEN=1 instance: every beat is last.
    @(posedge clk); #1;
    wready1_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pend1_q.push_back(32'h5555_0000 + DW'(i));
      exp1_q.push_back('{data: 32'h5555_0000 + DW'(i), last: 1'b1});
    end
    k = 0;
    while (exp1_q.size() != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    chk("len1_drained", exp1_q.size(), 0);
    @(negedge clk);
    chk("len1_busy", busy1_o, 1'b0);
`ifdef WBUF_DRAIN_STATS_EN
    chk("len1_beats", beats1_o, 32'd3);
    chk("len1_bursts", bursts1_o, 32'd3);
`endif

    // Reset while a beat is waiting in S_SEND.
    @(posedge clk); #1;
    wready_i = 1'b0;
    push_words(4, 32'h3333_0000);
    wait_valid(20);
    rst_n = 1'b0;
    exp_q.delete();
    burst_idx = 0;
    @(posedge clk); #1;
    chk("midrst_wvalid", wvalid_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_rden", rden_o, 1'b0);
    chk("midrst_wlast", wlast_o, 1'b0);
    chk("midrst_wdata", wdata_o, '0);
    rst_n = 1'b1;
    wready_i = 1'b1;
    @(posedge clk); #1;
    push_words(4, 32'h4444_0000);
    wait_drain(40);
    @(negedge clk);
    chk("busy_after_rst_burst", busy_o, 1'b0);

    // Random pushes and wready over 1000 cycles; order and last placement
    // are checked by the scoreboard, underflow by the monitor.
    @(posedge clk); #1;
    for (int c = 0; c < 1000; c++) begin
      wready_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        push_words(1, 32'h7000_0000 + DW'(c));
      end else begin
        @(posedge clk); #1;
      end
    end
    wready_i = 1'b1;
    wait_drain(5000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rand_no_extra_pops", fifo_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
